// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead adder with a single registered output stage.
// Carries are formed from explicit generate/propagate lookahead terms
// (no ripple chain, no '+'). Results, group P/G, overflow and zero
// flags are captured on the rising edge when in_valid is high and held
// otherwise. out_valid marks the cycle a new result appears.
module cla_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       in_valid,
    output logic [3:0] sum,
    output logic       cout,
    output logic       out_valid,
    output logic       grp_p,
    output logic       grp_g,
    output logic       ovf,
    output logic       zero
);

    // Stage p0: combinational lookahead datapath (no reset)
    logic [3:0] w_g_p0;
    logic [3:0] w_p_p0;
    logic [4:0] w_c_p0;
    logic [3:0] w_sum_p0;
    logic       w_grp_p_p0;
    logic       w_grp_g_p0;
    logic       w_ovf_p0;
    logic       w_zero_p0;

    // Stage p1: output registers
    logic [3:0] r_sum_p1;
    logic       r_cout_p1;
    logic       r_grp_p_p1;
    logic       r_grp_g_p1;
    logic       r_ovf_p1;
    logic       r_zero_p1;
    logic       r_vld_p1;

    // Per-bit generate/propagate, flat lookahead carries and derived flags
    always_comb begin
        w_g_p0 = a & b;
        w_p_p0 = a ^ b;

        w_c_p0[0] = cin;
        w_c_p0[1] = w_g_p0[0]
                  | (w_p_p0[0] & cin);
        w_c_p0[2] = w_g_p0[1]
                  | (w_p_p0[1] & w_g_p0[0])
                  | (w_p_p0[1] & w_p_p0[0] & cin);
        w_c_p0[3] = w_g_p0[2]
                  | (w_p_p0[2] & w_g_p0[1])
                  | (w_p_p0[2] & w_p_p0[1] & w_g_p0[0])
                  | (w_p_p0[2] & w_p_p0[1] & w_p_p0[0] & cin);
        w_c_p0[4] = w_g_p0[3]
                  | (w_p_p0[3] & w_g_p0[2])
                  | (w_p_p0[3] & w_p_p0[2] & w_g_p0[1])
                  | (w_p_p0[3] & w_p_p0[2] & w_p_p0[1] & w_g_p0[0])
                  | (w_p_p0[3] & w_p_p0[2] & w_p_p0[1] & w_p_p0[0] & cin);

        w_sum_p0 = w_p_p0 ^ w_c_p0[3:0];

        // Group terms let this block chain into a wider lookahead tree;
        // c4 is identically grp_g | grp_p & cin.
        w_grp_p_p0 = &w_p_p0;
        w_grp_g_p0 = w_g_p0[3]
                   | (w_p_p0[3] & w_g_p0[2])
                   | (w_p_p0[3] & w_p_p0[2] & w_g_p0[1])
                   | (w_p_p0[3] & w_p_p0[2] & w_p_p0[1] & w_g_p0[0]);

        // Signed overflow: carry into the sign bit differs from carry out
        w_ovf_p0  = w_c_p0[3] ^ w_c_p0[4];
        w_zero_p0 = ~|w_sum_p0;
    end

    // Result registers: load on valid input, hold otherwise, clear on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_p1   <= 4'd0;
            r_cout_p1  <= 1'b0;
            r_grp_p_p1 <= 1'b0;
            r_grp_g_p1 <= 1'b0;
            r_ovf_p1   <= 1'b0;
            r_zero_p1  <= 1'b0;
        end else if (in_valid) begin
            r_sum_p1   <= w_sum_p0;
            r_cout_p1  <= w_c_p0[4];
            r_grp_p_p1 <= w_grp_p_p0;
            r_grp_g_p1 <= w_grp_g_p0;
            r_ovf_p1   <= w_ovf_p0;
            r_zero_p1  <= w_zero_p0;
        end
    end

    // Valid flag follows in_valid with one cycle of latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= in_valid;
        end
    end

    assign sum       = r_sum_p1;
    assign cout      = r_cout_p1;
    assign grp_p     = r_grp_p_p1;
    assign grp_g     = r_grp_g_p1;
    assign ovf       = r_ovf_p1;
    assign zero      = r_zero_p1;
    assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_cla_4bit.sv
// Self-checking bench for cla_4bit: expected results are computed from
// integer arithmetic when a vector is driven, queued, and compared when
// the registered result appears one cycle later.
module tb_cla_4bit;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       in_valid;
    logic [3:0] sum;
    logic       cout;
    logic       out_valid;
    logic       grp_p;
    logic       grp_g;
    logic       ovf;
    logic       zero;

    typedef struct packed {
        logic [3:0] sum;
        logic       cout;
        logic       gp;
        logic       gg;
        logic       ovf;
        logic       zero;
        logic       vld;
    } res_t;

    res_t q[$];
    res_t m;          // expected state of the output registers
    int   n_vec;
    int   n_err;
    int   n_chk;

    cla_4bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid),
        .grp_p     (grp_p),
        .grp_g     (grp_g),
        .ovf       (ovf),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t model(input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        res_t r;
        int   t;
        int   ab;
        ab     = int'(ta) + int'(tb);
        t      = ab + int'(tc);
        r.sum  = t[3:0];
        r.cout = (t > 15);
        r.gp   = ((ta ^ tb) == 4'hF);
        r.gg   = (ab > 15);
        r.ovf  = (ta[3] == tb[3]) && (r.sum[3] != ta[3]);
        r.zero = (r.sum == 4'd0);
        r.vld  = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d (a=%0d b=%0d cin=%0d)", tag, obs, exp, a, b, cin);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ".sum"},       sum,               m.sum);
        chk({where, ".cout"},      {3'b0, cout},      {3'b0, m.cout});
        chk({where, ".grp_p"},     {3'b0, grp_p},     {3'b0, m.gp});
        chk({where, ".grp_g"},     {3'b0, grp_g},     {3'b0, m.gg});
        chk({where, ".ovf"},       {3'b0, ovf},       {3'b0, m.ovf});
        chk({where, ".zero"},      {3'b0, zero},      {3'b0, m.zero});
        chk({where, ".out_valid"}, {3'b0, out_valid}, {3'b0, m.vld});
    endtask

    // One clock of stimulus: drive on the falling edge, check 1ns after rising edge.
    task automatic step(input string where, input logic [3:0] ta, input logic [3:0] tb,
                        input logic tc, input logic tv);
        @(negedge clk);
        in_valid = tv;
        if (tv) begin
            a   = ta;
            b   = tb;
            cin = tc;
            q.push_back(model(ta, tb, tc));
        end else begin
            a   = 4'bxxxx;
            b   = 4'bzzzz;
            cin = 1'bx;
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (tv) begin
            n_chk++;
            assert (q.size() != 0) else begin
                n_err++;
                $error("FAIL %s.queue observed=empty expected=entry", where);
            end
            if (q.size() != 0) m = q.pop_front();
        end else begin
            m.vld = 1'b0;
        end
        check_all(where);
    endtask

    task automatic reset_model();
        m = '0;
        q.delete();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        n_chk = 0;
        m     = '0;
        rst_n    = 1'b0;
        a        = 4'd0;
        b        = 4'd0;
        cin      = 1'b0;
        in_valid = 1'b0;

        // Power-on reset held across edges
        repeat (2) @(posedge clk);
        #1;
        reset_model();
        check_all("por");
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Get some non-zero state, then assert reset between edges
        step("pre", 4'd15, 4'd15, 1'b1, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        reset_model();
        check_all("async_rst");
        // Valid input during reset is discarded
        in_valid = 1'b1;
        a = 4'd3; b = 4'd4; cin = 1'b1;
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        #2 rst_n = 1'b1;

        step("zero_add", 4'd0,  4'd0,  1'b0, 1'b1);
        step("cin_only", 4'd0,  4'd0,  1'b1, 1'b1);
        step("prop",     4'd10, 4'd5,  1'b0, 1'b1);
        step("chain",    4'd10, 4'd5,  1'b1, 1'b1);
        step("wrap",     4'd15, 4'd1,  1'b0, 1'b1);
        step("max0",     4'd15, 4'd15, 1'b0, 1'b1);
        step("max1",     4'd15, 4'd15, 1'b1, 1'b1);
        step("ovf_pos",  4'd7,  4'd1,  1'b0, 1'b1);
        step("ovf_neg",  4'd8,  4'd8,  1'b0, 1'b1);

        // Single valid pulse then three idle cycles with X/Z on inputs
        step("pulse",    4'd6,  4'd9,  1'b0, 1'b1);
        step("idle1",    4'd0,  4'd0,  1'b0, 1'b0);
        step("idle2",    4'd0,  4'd0,  1'b0, 1'b0);
        step("idle3",    4'd0,  4'd0,  1'b0, 1'b0);

        // Reset mid-stream discards held result
        step("mid_a",    4'd9,  4'd4,  1'b1, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        reset_model();
        check_all("mid_rst");
        @(negedge clk);
        #2 rst_n = 1'b1;
        step("mid_b",    4'd2,  4'd3,  1'b0, 1'b1);

        // Exhaustive back-to-back sweep
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            step("sweep", v[8:5], v[4:1], v[0], 1'b1);
        end

        // Random vectors with random gaps
        for (int i = 0; i < 300; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic       rc;
            logic       rv;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 1'($urandom_range(0, 1));
            rv = ($urandom_range(0, 3) != 0);
            step("rand", ra, rb, rc, rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cla_4bit.md
CLA_4BIT -- requirements
Module: cla_4bit

Interface
REQ-001 Parameters: none; widths fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a  input  4  unsigned addend A.
REQ-005 b  input  4  unsigned addend B.
REQ-006 cin  input  1  carry-in.
REQ-007 in_valid  input  1  a/b/cin qualify this cycle.
REQ-008 sum  output  4  registered result bits [3:0].
REQ-009 cout  output  1  registered carry-out (result bit 4).
REQ-010 out_valid  output  1  sum/cout/flags hold a new result.
REQ-011 grp_p  output  1  registered group propagate, &(a^b).
REQ-012 grp_g  output  1  registered group generate.
REQ-013 ovf  output  1  registered two's-complement overflow.
REQ-014 zero  output  1  registered flag, sum == 4'd0.

Function
REQ-015 Per bit i: g[i] = a[i]&b[i]; p[i] = a[i]^b[i].
REQ-016 Carries use explicit lookahead equations from g, p, cin: c1 = g0|p0&cin; c2 = g1|p1&g0|p1&p0&cin; c3 and c4 expanded the same way; no ripple chain and no behavioural '+' operator.
REQ-017 sum[i] = p[i]^c[i] with c0 = cin; cout = c4.
REQ-018 grp_g = g3|p3&g2|p3&p2&g1|p3&p2&p1&g0; cout equals grp_g|grp_p&cin.
REQ-019 ovf = c3^c4.
REQ-020 Arithmetic result {cout,sum} equals a+b+cin exactly, range 0..31, for all 512 input combinations.
REQ-021 Latency is 1 cycle: inputs sampled at edge N when in_valid=1 appear on outputs after edge N, with out_valid=1.
REQ-022 When in_valid=0 at an edge: sum, cout, grp_p, grp_g, ovf and zero hold their previous values; out_valid goes 0.
REQ-023 No backpressure; one new result accepted every cycle; back-to-back valid inputs produce back-to-back results.
REQ-024 Wrap-around: 15+1+0 gives sum=0, cout=1, zero=1.
REQ-025 X or Z on inputs while in_valid=0 has no effect on outputs.

Reset
REQ-026 rst_n low immediately, without a clock edge, forces sum=0, cout=0, grp_p=0, grp_g=0, ovf=0, zero=0 and out_valid=0.
REQ-027 Reset asserted mid-stream discards any in-flight result; the first valid input sampled at a rising edge after rst_n deasserts produces the first result.
REQ-028 Combinational carry logic has no reset; only output registers are reset.

Verification
REQ-029 rst_n=0 asynchronously between edges -> all outputs 0 before the next edge; release, a=0 b=0 cin=0 valid -> sum=0 cout=0 zero=1 out_valid=1.
REQ-030 a=0 b=0 cin=1 -> sum=1 cout=0; a=10 b=5 cin=0 -> sum=15 cout=0 grp_p=1 grp_g=0.
REQ-031 a=10 b=5 cin=1 -> sum=0 cout=1 zero=1 (full propagate chain); a=15 b=1 cin=0 -> sum=0 cout=1.
REQ-032 a=15 b=15 cin=0 -> sum=14 cout=1; a=15 b=15 cin=1 -> sum=15 cout=1 grp_g=1; a=7 b=1 cin=0 -> sum=8 ovf=1.
REQ-033 Valid pulse followed by in_valid=0 for 3 cycles -> outputs hold, out_valid=1 for exactly one cycle.
REQ-034 Exhaustive sweep of all 512 (a,b,cin) combinations plus random back-to-back vectors -> {cout,sum} = a+b+cin one cycle later, zero and ovf consistent every cycle.
